// File: rtl/aq_idu_gpr_pkg.sv
// aq_idu_gpr_pkg
// Shared defaults for the IDU general-purpose register bank and the constant
// clog2 helper used to size entry indices.
//   GPR_WIDTH  : default data bits per entry
//   GPR_DEPTH  : default number of entries (power of two, >= 4)
//   GPR_NUM_WB : default number of writeback ports (1..4)
//   GPR_NUM_RD : default number of read ports (1..4)
package aq_idu_gpr_pkg;

  localparam int GPR_WIDTH  = 64;
  localparam int GPR_DEPTH  = 32;
  localparam int GPR_NUM_WB = 2;
  localparam int GPR_NUM_RD = 3;

  // Ceiling log2; usable in parameter and port-width expressions.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/aq_idu_gpr_bank_entry.sv
// aq_idu_gpr_bank_entry / gated_clk_cell
// One register-bank entry: its own clock gate, the data register and the
// write-hold mux. The write mux keeps the entry correct even when the ICG is
// forced open (module enable or scan), so the gate only saves switching.
// Ports (aq_idu_gpr_bank_entry):
//   forever_cpuclk      in   free-running clock
//   cpurst_b            in   asynchronous active-low reset
//   cp0_yy_clk_en       in   global ICG enable
//   cp0_idu_icg_en      in   module ICG enable (keeps the clock running)
//   pad_yy_icg_scan_en  in   scan ICG enable
//   wr_en               in   single-writer write to this entry
//   wr_data             in   data to capture
//   data                out  stored value
// Ports (gated_clk_cell):
//   clk_in, global_en, module_en, local_en, external_en, pad_yy_icg_scan_en
//   in; clk_out out (glitch-free gated clock, enable latched while clk low).
module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);

  logic clk_en_bf_latch;
  logic clk_en_latch;

  assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

  // Transparent-low latch: enable cannot change while the clock is high.
  always_latch begin
    if (!clk_in) begin
      clk_en_latch <= clk_en_bf_latch | pad_yy_icg_scan_en;
    end
  end

  assign clk_out = clk_in & clk_en_latch;

endmodule

module aq_idu_gpr_bank_entry #(
  parameter int WIDTH = 64
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             cp0_yy_clk_en,
  input  logic             cp0_idu_icg_en,
  input  logic             pad_yy_icg_scan_en,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] data
);

  logic             entry_clk;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;

  gated_clk_cell x_entry_gated_clk (
    .clk_in             (forever_cpuclk),
    .global_en          (cp0_yy_clk_en),
    .module_en          (cp0_idu_icg_en),
    .local_en           (wr_en),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (entry_clk)
  );

  assign data_next = wr_en ? wr_data : data_reg;

  always_ff @(posedge entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      data_reg <= '0;
    end else begin
      data_reg <= data_next;
    end
  end

  assign data = data_reg;

endmodule

// File: rtl/aq_idu_gpr_bank.sv
// aq_idu_gpr_bank
// IDU register bank with per-entry pending (scoreboard) bits, multi-port
// writeback with multi-writer conflict detection, and combinational reads.
// Optional macro AQ_IDU_GPR_RD_BYPASS_EN: reads forward same-cycle
// single-writer writeback data and report the operand ready.
// Ports:
//   forever_cpuclk / cpurst_b                      clock, async active-low reset
//   cp0_yy_clk_en / cp0_idu_icg_en / pad_yy_icg_scan_en   ICG enables
//   rtu_idu_wb_vld/idx/data   per-port writeback (packed)
//   idu_alloc_vld/idx         destination allocation (sets pending)
//   rtu_idu_flush             clears all pending bits
//   idu_rd_idx                packed read indices
//   idu_rd_data / idu_rd_rdy  packed read data, operand ready per port
//   idu_wb_conflict_err       sticky: two writers hit one entry in a cycle
module aq_idu_gpr_bank
  import aq_idu_gpr_pkg::*;
#(
  parameter int WIDTH    = GPR_WIDTH,
  parameter int DEPTH    = GPR_DEPTH,
  parameter int NUM_WB   = GPR_NUM_WB,
  parameter int NUM_RD   = GPR_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                              forever_cpuclk,
  input  logic                              cpurst_b,
  input  logic                              cp0_yy_clk_en,
  input  logic                              cp0_idu_icg_en,
  input  logic                              pad_yy_icg_scan_en,
  input  logic [NUM_WB-1:0]                 rtu_idu_wb_vld,
  input  logic [NUM_WB*clog2(DEPTH)-1:0]    rtu_idu_wb_idx,
  input  logic [NUM_WB*WIDTH-1:0]           rtu_idu_wb_data,
  input  logic                              idu_alloc_vld,
  input  logic [clog2(DEPTH)-1:0]           idu_alloc_idx,
  input  logic                              rtu_idu_flush,
  input  logic [NUM_RD*clog2(DEPTH)-1:0]    idu_rd_idx,
  output logic [NUM_RD*WIDTH-1:0]           idu_rd_data,
  output logic [NUM_RD-1:0]                 idu_rd_rdy,
  output logic                              idu_wb_conflict_err
);

  localparam int IDXW = clog2(DEPTH);
  localparam int CNTW = 3;

  logic [DEPTH-1:0] wr_single;
  logic [DEPTH-1:0] wr_multi;
  logic [DEPTH-1:0] pend_reg;
  logic [DEPTH-1:0] pend_next;
  logic             err_reg;
  logic [WIDTH-1:0] ent_data [DEPTH];
`ifdef AQ_IDU_GPR_RD_BYPASS_EN
  logic [WIDTH-1:0] wb_sel_data [DEPTH];
`endif

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_ent
    if (ZERO_REG != 0 && gi == 0) begin : g_zero
      // Hardwired zero: never written, never pending, never a conflict.
      assign wr_single[gi] = 1'b0;
      assign wr_multi[gi]  = 1'b0;
      assign pend_next[gi] = 1'b0;
      assign ent_data[gi]  = '0;
`ifdef AQ_IDU_GPR_RD_BYPASS_EN
      assign wb_sel_data[gi] = '0;
`endif
    end else begin : g_reg
      logic [CNTW-1:0]  hit_cnt;
      logic [WIDTH-1:0] hit_data;
      logic             alloc_hit;

      // Count writers for this entry; OR-merged data is only meaningful
      // when exactly one port hits.
      always_comb begin
        hit_cnt  = '0;
        hit_data = '0;
        for (int p = 0; p < NUM_WB; p++) begin
          if (rtu_idu_wb_vld[p] && (rtu_idu_wb_idx[p*IDXW +: IDXW] == IDXW'(gi))) begin
            hit_cnt  = hit_cnt + CNTW'(1);
            hit_data = hit_data | rtu_idu_wb_data[p*WIDTH +: WIDTH];
          end
        end
      end

      assign wr_single[gi] = (hit_cnt == CNTW'(1));
      assign wr_multi[gi]  = (hit_cnt > CNTW'(1));
      assign alloc_hit     = idu_alloc_vld && (idu_alloc_idx == IDXW'(gi));
`ifdef AQ_IDU_GPR_RD_BYPASS_EN
      assign wb_sel_data[gi] = hit_data;
`endif

      // Flush beats alloc, alloc beats a completing writeback (the new
      // producer is still outstanding), conflicts leave the bit alone.
      assign pend_next[gi] = rtu_idu_flush ? 1'b0 :
                             alloc_hit     ? 1'b1 :
                             wr_single[gi] ? 1'b0 : pend_reg[gi];

      aq_idu_gpr_bank_entry #(
        .WIDTH (WIDTH)
      ) x_entry (
        .forever_cpuclk     (forever_cpuclk),
        .cpurst_b           (cpurst_b),
        .cp0_yy_clk_en      (cp0_yy_clk_en),
        .cp0_idu_icg_en     (cp0_idu_icg_en),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .wr_en              (wr_single[gi]),
        .wr_data            (hit_data),
        .data               (ent_data[gi])
      );
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      pend_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      pend_reg <= pend_next;
      if (|wr_multi) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign idu_wb_conflict_err = err_reg;

  for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [IDXW-1:0] rd_idx;
    assign rd_idx = idu_rd_idx[gi*IDXW +: IDXW];
`ifdef AQ_IDU_GPR_RD_BYPASS_EN
    assign idu_rd_data[gi*WIDTH +: WIDTH] = wr_single[rd_idx] ? wb_sel_data[rd_idx]
                                                              : ent_data[rd_idx];
    assign idu_rd_rdy[gi] = wr_single[rd_idx] | ~pend_reg[rd_idx];
`else
    assign idu_rd_data[gi*WIDTH +: WIDTH] = ent_data[rd_idx];
    assign idu_rd_rdy[gi] = ~pend_reg[rd_idx];
`endif
  end

endmodule

// File: tb/tb_aq_idu_gpr_bank.sv
// Self-checking bench for aq_idu_gpr_bank: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_aq_idu_gpr_bank;

  localparam int W   = 64;
  localparam int D   = 32;
  localparam int NWB = 2;
  localparam int NRD = 3;
  localparam int IW  = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clk_en;
  logic               icg_en;
  logic               scan_en;
  logic [NWB-1:0]     wb_vld;
  logic [NWB*IW-1:0]  wb_idx;
  logic [NWB*W-1:0]   wb_data;
  logic               alloc_vld;
  logic [IW-1:0]      alloc_idx;
  logic               flush;
  logic [NRD*IW-1:0]  rd_idx;
  logic [NRD*W-1:0]   rd_data;
  logic [NRD-1:0]     rd_rdy;
  logic               conflict_err;

  always #5 clk = ~clk;

  aq_idu_gpr_bank #(
    .WIDTH (W), .DEPTH (D), .NUM_WB (NWB), .NUM_RD (NRD), .ZERO_REG (1)
  ) dut (
    .forever_cpuclk      (clk),
    .cpurst_b            (rst_n),
    .cp0_yy_clk_en       (clk_en),
    .cp0_idu_icg_en      (icg_en),
    .pad_yy_icg_scan_en  (scan_en),
    .rtu_idu_wb_vld      (wb_vld),
    .rtu_idu_wb_idx      (wb_idx),
    .rtu_idu_wb_data     (wb_data),
    .idu_alloc_vld       (alloc_vld),
    .idu_alloc_idx       (alloc_idx),
    .rtu_idu_flush       (flush),
    .idu_rd_idx          (rd_idx),
    .idu_rd_data         (rd_data),
    .idu_rd_rdy          (rd_rdy),
    .idu_wb_conflict_err (conflict_err)
  );

  // Behavioural model: architectural contents, outstanding producers, error.
  logic [W-1:0] m_mem  [D];
  bit           m_pend [D];
  bit           m_err;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic m_reset();
    for (int e = 0; e < D; e++) begin
      m_mem[e]  = '0;
      m_pend[e] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  function automatic int writers(input int e);
    int n = 0;
    for (int p = 0; p < NWB; p++)
      if (wb_vld[p] && int'(wb_idx[p*IW +: IW]) == e) n++;
    return n;
  endfunction

  function automatic logic [W-1:0] writer_data(input int e);
    logic [W-1:0] d = '0;
    for (int p = 0; p < NWB; p++)
      if (wb_vld[p] && int'(wb_idx[p*IW +: IW]) == e) d = wb_data[p*W +: W];
    return d;
  endfunction

  task automatic model_read(input int idx, output logic [W-1:0] d, output logic r);
    d = m_mem[idx];
    r = !m_pend[idx];
`ifdef AQ_IDU_GPR_RD_BYPASS_EN
    if (idx != 0 && writers(idx) == 1) begin
      d = writer_data(idx);
      r = 1'b1;
    end
`endif
  endtask

  task automatic model_update();
    int           cnt  [D];
    logic [W-1:0] wdat [D];
    for (int e = 0; e < D; e++) begin
      cnt[e]  = writers(e);
      wdat[e] = writer_data(e);
    end
    for (int e = 1; e < D; e++) begin
      if (cnt[e] == 1) begin
        m_mem[e]  = wdat[e];
        m_pend[e] = 1'b0;
      end
      if (cnt[e] >= 2) m_err = 1'b1;
    end
    if (alloc_vld && alloc_idx != 0) m_pend[alloc_idx] = 1'b1;
    if (flush) for (int e = 0; e < D; e++) m_pend[e] = 1'b0;
  endtask

  task automatic compare_all();
    logic [W-1:0] ed;
    logic         er;
    for (int r = 0; r < NRD; r++) begin
      model_read(int'(rd_idx[r*IW +: IW]), ed, er);
      chk("rd_data", rd_data[r*W +: W], ed);
      chk("rd_rdy", W'(rd_rdy[r]), W'(er));
    end
    chk("conflict_err", W'(conflict_err), W'(m_err));
  endtask

  // One clock: compare in the low phase, advance the model at the edge.
  task automatic cycle();
    #1;
    compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
    $display("cyc %0d wb_vld=%b idx0=%0d idx1=%0d alloc=%b/%0d flush=%b err=%b",
             cyc, wb_vld, wb_idx[0 +: IW], wb_idx[IW +: IW], alloc_vld, alloc_idx,
             flush, conflict_err);
  endtask

  task automatic clear_in();
    wb_vld = '0; wb_idx = '0; wb_data = '0;
    alloc_vld = 1'b0; alloc_idx = '0; flush = 1'b0;
  endtask

  task automatic set_wb(input int p, input int idx, input logic [W-1:0] d);
    wb_vld[p] = 1'b1;
    wb_idx[p*IW +: IW] = IW'(idx);
    wb_data[p*W +: W] = d;
  endtask

  task automatic set_rd(input int r, input int idx);
    rd_idx[r*IW +: IW] = IW'(idx);
  endtask

  task automatic rand_inputs(input bit allow_conflict);
    clear_in();
    for (int p = 0; p < NWB; p++) begin
      wb_vld[p] = ($urandom_range(0, 99) < 40);
      wb_idx[p*IW +: IW] = ($urandom_range(0, 3) == 0) ? IW'($urandom_range(0, 3))
                                                       : IW'($urandom_range(0, D-1));
      wb_data[p*W +: W] = {$urandom(), $urandom()};
    end
    if (!allow_conflict && wb_vld[1] && wb_vld[0] &&
        wb_idx[IW +: IW] == wb_idx[0 +: IW] && wb_idx[0 +: IW] != 0)
      wb_vld[1] = 1'b0;
    alloc_vld = ($urandom_range(0, 99) < 30);
    alloc_idx = IW'($urandom_range(0, D-1));
    flush     = ($urandom_range(0, 99) < 3);
    for (int r = 0; r < NRD; r++)
      set_rd(r, $urandom_range(0, 1) ? int'(wb_idx[(r % NWB)*IW +: IW])
                                     : int'($urandom_range(0, D-1)));
  endtask

  initial begin
    clk_en = 1'b1; icg_en = 1'b0; scan_en = 1'b0;
    rst_n = 1'b0;
    clear_in();
    rd_idx = '0;
    m_reset();
    repeat (2) @(negedge clk);

    // Reset state: every index reads zero and ready, no error.
    for (int i = 0; i < D; i++) begin
      for (int r = 0; r < NRD; r++) set_rd(r, (i + r) % D);
      #1;
      for (int r = 0; r < NRD; r++) begin
        chk("rst_data", rd_data[r*W +: W], '0);
        chk("rst_rdy", W'(rd_rdy[r]), W'(1));
      end
      chk("rst_err", W'(conflict_err), '0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Single write to entry 5.
    clear_in();
    set_wb(0, 5, 64'hDEAD_BEEF_0000_0001);
    set_rd(0, 5);
    #1;
`ifdef AQ_IDU_GPR_RD_BYPASS_EN
    chk("wr5_same", rd_data[0 +: W], 64'hDEAD_BEEF_0000_0001);
`else
    chk("wr5_same", rd_data[0 +: W], 64'h0);
`endif
    cycle();
    clear_in();
    #1;
    chk("wr5_next", rd_data[0 +: W], 64'hDEAD_BEEF_0000_0001);
    cycle();

    // Pending bit on entry 9.
    alloc_vld = 1'b1; alloc_idx = 5'd9; set_rd(1, 9);
    cycle();
    clear_in();
    #1;
    chk("alloc9_rdy", W'(rd_rdy[1]), W'(0));
    set_wb(1, 9, 64'h44);
    #1;
`ifdef AQ_IDU_GPR_RD_BYPASS_EN
    chk("wb9_same_rdy", W'(rd_rdy[1]), W'(1));
`else
    chk("wb9_same_rdy", W'(rd_rdy[1]), W'(0));
`endif
    cycle();
    clear_in();
    #1;
    chk("wb9_next_rdy", W'(rd_rdy[1]), W'(1));
    chk("wb9_next_data", rd_data[W +: W], 64'h44);
    alloc_vld = 1'b1; alloc_idx = 5'd9; set_wb(0, 9, 64'h55);
    cycle();
    clear_in();
    #1;
    chk("alloc_wb9_rdy", W'(rd_rdy[1]), W'(0));
    chk("alloc_wb9_data", rd_data[W +: W], 64'h55);

    // Flush overrides a same-cycle alloc.
    alloc_vld = 1'b1; alloc_idx = 5'd3; cycle();
    alloc_vld = 1'b1; alloc_idx = 5'd4; cycle();
    clear_in();
    set_rd(0, 3); set_rd(1, 4); set_rd(2, 6);
    #1;
    chk("alloc3_rdy", W'(rd_rdy[0]), W'(0));
    chk("alloc4_rdy", W'(rd_rdy[1]), W'(0));
    flush = 1'b1; alloc_vld = 1'b1; alloc_idx = 5'd6;
    cycle();
    clear_in();
    #1;
    chk("flush_rdy3", W'(rd_rdy[0]), W'(1));
    chk("flush_rdy4", W'(rd_rdy[1]), W'(1));
    chk("flush_rdy6", W'(rd_rdy[2]), W'(1));
    cycle();

    // Entry 0 is hardwired; both writers on it is not an error.
    set_wb(0, 0, 64'hFF); set_wb(1, 0, 64'hFE);
    alloc_vld = 1'b1; alloc_idx = 5'd0; set_rd(0, 0);
    cycle();
    clear_in();
    #1;
    chk("zero_data", rd_data[0 +: W], 64'h0);
    chk("zero_rdy", W'(rd_rdy[0]), W'(1));
    chk("zero_err", W'(conflict_err), W'(0));

    // Random traffic without multi-writer conflicts.
    for (int i = 0; i < 600; i++) begin
      rand_inputs(1'b0);
      cycle();
    end

    // Conflict on entry 7 over stored 0x33.
    clear_in();
    set_wb(0, 7, 64'h33);
    cycle();
    clear_in();
    set_wb(0, 7, 64'h11); set_wb(1, 7, 64'h22); set_rd(0, 7);
    #1;
    chk("conf7_same", rd_data[0 +: W], 64'h33);
    chk("conf7_err_before", W'(conflict_err), W'(0));
    cycle();
    clear_in();
    #1;
    chk("conf7_data", rd_data[0 +: W], 64'h33);
    chk("conf7_err", W'(conflict_err), W'(1));
    repeat (100) cycle();
    chk("conf7_err_held", W'(conflict_err), W'(1));

    // Asynchronous reset in the middle of traffic.
    rand_inputs(1'b1);
    #2 rst_n = 1'b0;
    #1;
    for (int r = 0; r < NRD; r++) begin
      chk("midrst_data", rd_data[r*W +: W], '0);
      chk("midrst_rdy", W'(rd_rdy[r]), W'(1));
    end
    chk("midrst_err", W'(conflict_err), W'(0));
    @(posedge clk);
    @(negedge clk);
    m_reset();
    rst_n = 1'b1;
    clear_in();
    cycle();

    // Random traffic including conflicts.
    for (int i = 0; i < 600; i++) begin
      rand_inputs(1'b1);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aq_idu_gpr_bank.md
AQ_IDU_GPR_BANK -- requirements
Module: aq_idu_gpr_bank

Interface
REQ-001 Parameters SHALL be: WIDTH, 64, data bits per entry; DEPTH, 32, entries (power of two, >=4); NUM_WB, 2, writeback ports (1..4); NUM_RD, 3, read ports (1..4); ZERO_REG, 1, entry 0 hardwired to zero when 1.
REQ-002 Localparam IDXW SHALL equal clog2(DEPTH).
REQ-003 Ports SHALL be, clock and reset first:
forever_cpuclk  in  1  single clock, rising edge.
cpurst_b  in  1  asynchronous active-low reset.
cp0_yy_clk_en / cp0_idu_icg_en / pad_yy_icg_scan_en  in  1 each  global, module and scan ICG enables.
rtu_idu_wb_vld  in  NUM_WB  per-port writeback valid.
rtu_idu_wb_idx  in  NUM_WB*IDXW  packed writeback entry index.
rtu_idu_wb_data  in  NUM_WB*WIDTH  packed writeback data.
idu_alloc_vld  in  1  destination allocation valid.
idu_alloc_idx  in  IDXW  allocated destination entry.
rtu_idu_flush  in  1  pipeline flush.
idu_rd_idx  in  NUM_RD*IDXW  packed read indices.
idu_rd_data  out  NUM_RD*WIDTH  packed read data.
idu_rd_rdy  out  NUM_RD  operand ready (no outstanding producer).
idu_wb_conflict_err  out  1  sticky multi-writer error.

Function
REQ-004 Entry e SHALL be written at the clock edge when exactly one port p has wb_vld[p]=1 and wb_idx[p]=e; its data is captured.
REQ-005 When two or more valid ports target the same entry in one cycle, that entry SHALL hold its old value and keep its pending bit unchanged, and idu_wb_conflict_err SHALL be set at the next edge.
REQ-006 idu_wb_conflict_err SHALL stay 1 until reset.
REQ-007 Each entry SHALL have a pending bit: set at the edge by idu_alloc_vld targeting it; cleared by a single-writer writeback to it.
REQ-008 Alloc and single-writer writeback to the same entry in the same cycle: pending SHALL end set; data SHALL still be written.
REQ-009 rtu_idu_flush SHALL clear all pending bits at the next edge; it overrides a same-cycle alloc; writebacks in that cycle still update data.
REQ-010 With ZERO_REG=1, entry 0 SHALL read 0 with rd_rdy=1; writes, allocs and conflicts targeting entry 0 SHALL be ignored (no error).
REQ-011 Reads SHALL be combinational from rd_idx.
REQ-012 Each entry SHALL be clocked through its own gated_clk_cell; local enable = single-writer write to that entry, or reset deassertion handling not required (reset is asynchronous).

Reset
REQ-013 While cpurst_b=0: all entries 0, all pending bits 0, idu_wb_conflict_err 0; idu_rd_data 0 and idu_rd_rdy all 1 (combinational from reset state).
REQ-014 Reset asserted mid-operation SHALL take effect immediately, discarding same-cycle writes and allocs.

Configuration
REQ-015 Macro AQ_IDU_GPR_RD_BYPASS_EN defined: read port r SHALL return same-cycle single-writer writeback data for its index and assert rd_rdy for it even if pending; conflicting writers give stored data and rd_rdy=~pending.
REQ-016 Macro undefined: idu_rd_data SHALL be stored value only; idu_rd_rdy SHALL be ~pending; write visible one cycle after capture.

Structure
REQ-017 Package aq_idu_gpr_pkg SHALL hold the WIDTH/DEPTH/NUM_WB/NUM_RD defaults and the clog2 function.
REQ-018 One sub-module aq_idu_gpr_bank_entry (gated_clk_cell, data register, write mux) SHALL be instantiated DEPTH times (minus entry 0 when ZERO_REG=1).

Verification
REQ-019 Reset, then read all indices -> data 0, rdy 1, err 0.
REQ-020 Port0 writes entry 5 = 0xDEAD_BEEF_0000_0001 -> bypass build: same-cycle rd_data shows value; non-bypass: visible next cycle.
REQ-021 Ports 0 and 1 both write entry 7 (0x11, 0x22) over stored 0x33 -> entry stays 0x33, err=1 next cycle and held after 100 idle cycles.
REQ-022 Alloc entry 9, read 9 -> rdy 0; writeback 9 with 0x44 -> rdy 1 next cycle (same cycle in bypass build); alloc+wb same cycle -> rdy stays 0.
REQ-023 Alloc entries 3 and 4, flush with alloc entry 6 -> all pending clear, entry 6 rdy 1.
REQ-024 ZERO_REG=1, write 0xFF to entry 0 and alloc entry 0 -> reads 0, rdy 1, err 0.
